design1_wrapper: RTL and testbench

- DAC playback engine: a single-beat AXI4 (512-bit) slave loads a waveform memory and three control registers (DAC enable, start pointer, stop pointer).
- While enabled, it streams memory words between the start and stop pointers on a 512-bit AXI-Stream master, wrapping continuously. The stream feeds the RF-DAC datapath.
- Sits between the processor/VIP AXI interconnect and the DAC AXIS input.

---
 rtl/design1_wrapper_if.sv | 44 ++++
 rtl/design1_wrapper.sv | 244 ++++++++++++++++++++++++
 tb/tb_design1_wrapper.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/design1_wrapper_if.sv
// Bus bundles for the DAC playback engine:
// a single-beat 512-bit AXI4 slave port and a 512-bit AXI-Stream port.
interface axi4_512_if #(
   parameter int AW     = 32,
   parameter int DATA_W = 512
);
   logic [AW-1:0]       awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [AW-1:0]       araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

interface axis_512_if #(
   parameter int DATA_W = 512
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tvalid, input tready);
   modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/design1_wrapper.sv
// DAC playback engine: AXI4 slave loads a waveform memory plus control registers,
// and the memory range [start, stop) is streamed continuously on AXI-Stream.
module design1_wrapper #(
   parameter int DEPTH  = 1024,
   parameter int AW     = 32,
   parameter int DATA_W = 512
) (
   input  logic       aclk,
   input  logic       aresetn,
   axi4_512_if.slave  s_axi,
   axis_512_if.master axis_0
);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = DATA_W / 8;
   localparam logic [AW-1:0] MEM_BASE = AW'(32'hC000_0000);
   localparam logic [AW-1:0] MEM_END  = MEM_BASE + AW'(DEPTH * 64);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_FETCH, RD_RESP} rd_state_t;
   typedef enum logic [2:0] {SEL_NONE, SEL_EN, SEL_START, SEL_STOP, SEL_MEM} sel_t;

   function automatic sel_t decode(input logic [AW-1:0] addr);
      sel_t sel;
      sel = SEL_NONE;
      if (addr >= MEM_BASE && addr < MEM_END) begin
         sel = SEL_MEM;
      end else begin
         case (addr[AW-1:AW-16])
            16'h4000: sel = SEL_EN;
            16'h4001: sel = SEL_START;
            16'h4002: sel = SEL_STOP;
            default:  sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

   function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
      end
      return res;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   wr_state_t wr_state, wr_state_nxt;
   rd_state_t rd_state, rd_state_nxt;
   logic      awready_c, bvalid_c, arready_c, rvalid_c;
   logic      wr_fire, rd_fire;
   sel_t      wr_sel, rd_sel_p0;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [1:0]    bresp_q, rresp_q;
   logic [DATA_W-1:0] rdata_q, rd_mem_p0;

   logic        dac_en, en_d;
   logic [31:0] start_ptr, stop_ptr;

   logic [IW-1:0] rd_ptr, cur_start, cur_stop, start_word, stop_word;
   logic [IW-1:0] fetch_addr, next_addr, wrap_start, wrap_stop;
   logic          en_rise, fetch, wrap, pop;
   logic [1:0]    occ;
   logic          vld_p0, skid_vld, tvalid_q;
   logic [DATA_W-1:0] fetch_data_p0, skid_data, tdata_q;
   logic          out_load, out_from_skid, out_from_p0, skid_load;

   assign wr_sel  = decode(s_axi.awaddr);
   assign wr_idx  = s_axi.awaddr[6+IW-1:6];
   assign rd_idx  = s_axi.araddr[6+IW-1:6];
   assign wr_fire = (wr_state == WR_ACCEPT) && s_axi.awvalid && s_axi.wvalid;
   assign rd_fire = (rd_state == RD_ACCEPT) && s_axi.arvalid;

   assign s_axi.awready = awready_c;
   assign s_axi.wready  = awready_c;
   assign s_axi.bvalid  = bvalid_c;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_c;
   assign s_axi.rvalid  = rvalid_c;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   always_comb begin
      wr_state_nxt = wr_state;
      awready_c    = 1'b0;
      bvalid_c     = 1'b0;
      case (wr_state)
         WR_IDLE:   if (s_axi.awvalid && s_axi.wvalid) wr_state_nxt = WR_ACCEPT;
         WR_ACCEPT: begin
            awready_c    = 1'b1;
            wr_state_nxt = wr_fire ? WR_RESP : WR_IDLE;
         end
         WR_RESP: begin
            bvalid_c = 1'b1;
            if (s_axi.bready) wr_state_nxt = WR_IDLE;
         end
         default:   wr_state_nxt = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      arready_c    = 1'b0;
      rvalid_c     = 1'b0;
      case (rd_state)
         RD_IDLE:   if (s_axi.arvalid) rd_state_nxt = RD_ACCEPT;
         RD_ACCEPT: begin
            arready_c    = 1'b1;
            rd_state_nxt = rd_fire ? RD_FETCH : RD_IDLE;
         end
         RD_FETCH:  rd_state_nxt = RD_RESP;
         RD_RESP: begin
            rvalid_c = 1'b1;
            if (s_axi.rready) rd_state_nxt = RD_IDLE;
         end
         default:   rd_state_nxt = RD_IDLE;
      endcase
   end

   // Control registers and write response
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dac_en    <= 1'b0;
         start_ptr <= '0;
         stop_ptr  <= '0;
         bresp_q   <= RESP_OKAY;
      end else if (wr_fire) begin
         bresp_q <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
         case (wr_sel)
            SEL_EN:    if (s_axi.wstrb[0]) dac_en <= s_axi.wdata[0];
            SEL_START: start_ptr <= merge32(start_ptr, s_axi.wdata[31:0], s_axi.wstrb[3:0]);
            SEL_STOP:  stop_ptr  <= merge32(stop_ptr, s_axi.wdata[31:0], s_axi.wstrb[3:0]);
            default:   ;
         endcase
      end
   end

   // Read stage p0: address decoded, memory word fetched; next stage forms the response
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_sel_p0 <= SEL_NONE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         if (rd_fire) rd_sel_p0 <= decode(s_axi.araddr);
         if (rd_state == RD_FETCH) begin
            rresp_q <= (rd_sel_p0 == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            case (rd_sel_p0)
               SEL_EN:    rdata_q <= DATA_W'(dac_en);
               SEL_START: rdata_q <= DATA_W'(start_ptr);
               SEL_STOP:  rdata_q <= DATA_W'(stop_ptr);
               SEL_MEM:   rdata_q <= rd_mem_p0;
               default:   rdata_q <= '0;
            endcase
         end
      end
   end

   // Both read ports see pre-write contents when colliding with an AXI write
   always_ff @(posedge aclk) begin
      if (wr_fire && wr_sel == SEL_MEM) begin
         for (int b = 0; b < SW; b++) begin
            if (s_axi.wstrb[b]) mem[wr_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
         end
      end
      if (rd_fire) rd_mem_p0 <= mem[rd_idx];
      if (fetch) fetch_data_p0 <= mem[fetch_addr];
      if (skid_load) skid_data <= fetch_data_p0;
   end

   assign start_word = start_ptr[6+IW-1:6];
   assign stop_word  = stop_ptr[6+IW-1:6];
   assign en_rise    = dac_en && !en_d;
   assign pop        = tvalid_q && axis_0.tready;
   assign occ        = {1'b0, tvalid_q} + {1'b0, skid_vld} + {1'b0, vld_p0};
   // Words in flight never exceed output + skid capacity, so a fetched word always lands
   assign fetch      = dac_en && ((occ - {1'b0, pop}) < 2'd2);
   assign fetch_addr = en_rise ? start_word : rd_ptr;
   assign wrap_start = en_rise ? start_word : cur_start;
   assign wrap_stop  = en_rise ? stop_word  : cur_stop;
   assign next_addr  = fetch_addr + IW'(1);
   assign wrap       = (wrap_stop <= wrap_start) || (next_addr == wrap_stop);

   assign out_load      = dac_en && (!tvalid_q || pop);
   assign out_from_skid = out_load && skid_vld;
   assign out_from_p0   = out_load && !skid_vld && vld_p0;
   assign skid_load     = dac_en && vld_p0 && !out_from_p0;

   assign axis_0.tdata  = tdata_q;
   assign axis_0.tvalid = tvalid_q;

   // Stream stage p0: fetch issued; following edge moves the word into output or skid
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         en_d      <= 1'b0;
         rd_ptr    <= '0;
         cur_start <= '0;
         cur_stop  <= '0;
         vld_p0    <= 1'b0;
         skid_vld  <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
      end else begin
         en_d   <= dac_en;
         vld_p0 <= fetch;
         if (fetch) begin
            if (wrap) begin
               rd_ptr    <= start_word;
               cur_start <= start_word;
               cur_stop  <= stop_word;
            end else begin
               rd_ptr <= next_addr;
               if (en_rise) begin
                  cur_start <= start_word;
                  cur_stop  <= stop_word;
               end
            end
         end
         if (!dac_en) begin
            skid_vld <= 1'b0;
            tvalid_q <= 1'b0;
         end else begin
            if (skid_load)          skid_vld <= 1'b1;
            else if (out_from_skid) skid_vld <= 1'b0;
            if (out_load)      tvalid_q <= skid_vld || vld_p0;
            if (out_from_skid) tdata_q  <= skid_data;
            else if (out_from_p0) tdata_q <= fetch_data_p0;
         end
      end
   end
endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for the DAC playback engine: register/memory access over AXI,
// stream ordering, wrap, backpressure, disable and asynchronous reset.
module tb_design1_wrapper;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi4_512_if #(.AW(32), .DATA_W(512)) s_axi ();
   axis_512_if #(.DATA_W(512))          axis_0 ();

   design1_wrapper #(.DEPTH(1024), .AW(32), .DATA_W(512)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_axi   (s_axi),
      .axis_0  (axis_0)
   );

   int checks = 0;
   int errors = 0;
   logic [511:0] w0, w1;

   localparam logic [31:0] A_EN    = 32'h4000_0000;
   localparam logic [31:0] A_START = 32'h4001_0000;
   localparam logic [31:0] A_STOP  = 32'h4002_0000;
   localparam logic [31:0] A_MEM   = 32'hC000_0000;

   function automatic logic [511:0] word_val(input int i);
      if (i == 0) return w0;
      if (i == 1) return w1;
      return 512'(i);
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [511:0] data,
                            input logic [63:0] strb, output logic [1:0] resp, output bit ok);
      ok = 1'b0;
      resp = 2'bxx;
      @(negedge aclk);
      s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (s_axi.awready && s_axi.wready) begin ok = 1'b1; break; end
      end
      if (ok) begin @(posedge aclk); #1; end
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      if (!ok) return;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (s_axi.bvalid) begin ok = 1'b1; resp = s_axi.bresp; break; end
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [511:0] data,
                           output logic [1:0] resp, output bit ok);
      ok = 1'b0;
      data = 'x;
      resp = 2'bxx;
      @(negedge aclk);
      s_axi.araddr = addr; s_axi.arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (s_axi.arready) begin ok = 1'b1; break; end
      end
      if (ok) begin @(posedge aclk); #1; end
      s_axi.arvalid = 1'b0;
      if (!ok) return;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (s_axi.rvalid) begin ok = 1'b1; data = s_axi.rdata; resp = s_axi.rresp; break; end
      end
   endtask

   task automatic test_reset();
      logic [1:0] resp; bit ok;
      repeat (3) @(negedge aclk);
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid} !== 5'b0) begin
         errors++; $display("FAIL reset_handshake: got %b expected 00000",
            {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid});
      end
      checks++;
      if (s_axi.rdata !== 512'h0 || s_axi.bresp !== 2'b00 || s_axi.rresp !== 2'b00) begin
         errors++; $display("FAIL reset_resp: bresp %b rresp %b expected 00 and rdata 0", s_axi.bresp, s_axi.rresp);
      end
      checks++;
      if (axis_0.tvalid !== 1'b0 || axis_0.tdata !== 512'h0) begin
         errors++; $display("FAIL reset_axis: tvalid %b expected 0, tdata %h expected 0", axis_0.tvalid, axis_0.tdata);
      end
      aresetn = 1'b1;
      axi_write(A_EN, 512'h0, '1, resp, ok);
      checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL wr_en0: ok %0d resp %b expected 00", ok, resp); end
      axi_write(A_START, 512'h0, '1, resp, ok);
      checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL wr_start0: ok %0d resp %b expected 00", ok, resp); end
      axi_write(A_STOP, 512'h0, '1, resp, ok);
      checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL wr_stop0: ok %0d resp %b expected 00", ok, resp); end
      repeat (4) @(negedge aclk);
      checks++; if (axis_0.tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid: got %b expected 0", axis_0.tvalid); end
   endtask

   task automatic test_mem_rw();
      logic [1:0] resp; bit ok; logic [511:0] rd, exp;
      axi_write(A_MEM, w0, '1, resp, ok);
      axi_write(A_MEM + 32'h40, w1, '1, resp, ok);
      axi_read(A_MEM, rd, resp, ok);
      checks++; if (!ok || resp !== 2'b00 || rd !== w0) begin errors++; $display("FAIL rd_word0: got %h expected %h", rd, w0); end
      axi_read(A_MEM + 32'h7F, rd, resp, ok);
      checks++; if (!ok || resp !== 2'b00 || rd !== w1) begin errors++; $display("FAIL rd_word1: got %h expected %h", rd, w1); end
      axi_write(A_MEM + 32'hF00, '1, '1, resp, ok);
      axi_write(A_MEM + 32'hF00, 512'h0, 64'h1, resp, ok);
      exp = '1; exp[7:0] = 8'h00;
      axi_read(A_MEM + 32'hF00, rd, resp, ok);
      checks++; if (!ok || rd !== exp) begin errors++; $display("FAIL rd_strobe: got %h expected %h", rd, exp); end
      axi_write(A_START, 512'hAABB_CCDD, 64'h3, resp, ok);
      axi_read(A_START, rd, resp, ok);
      checks++; if (!ok || resp !== 2'b00 || rd !== 512'h0000_CCDD) begin errors++; $display("FAIL rd_start_strb: got %h expected 0000ccdd", rd[31:0]); end
   endtask

   task automatic test_alternate();
      logic [1:0] resp; bit ok; int lat;
      axi_write(A_START, 512'h0, '1, resp, ok);
      axi_write(A_STOP, 512'h80, '1, resp, ok);
      axis_0.tready = 1'b1;
      axi_write(A_EN, 512'h1, '1, resp, ok);
      lat = -1;
      for (int i = 0; i <= 3; i++) begin
         if (axis_0.tvalid) begin lat = i; break; end
         @(negedge aclk);
      end
      checks++; if (lat < 0) begin errors++; $display("FAIL enable_latency: tvalid not seen, required within 3 cycles"); end
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (axis_0.tvalid !== 1'b1 || axis_0.tdata !== word_val(c % 2)) begin
            errors++; $display("FAIL alt_seq[%0d]: tvalid %b data %h expected %h", c, axis_0.tvalid, axis_0.tdata, word_val(c % 2));
         end
         @(negedge aclk);
      end
   endtask

   task automatic test_long_seq();
      logic [1:0] resp; bit ok; int idx;
      axi_write(A_EN, 512'h0, '1, resp, ok);
      for (int k = 2; k < 48; k++) begin
         axi_write(A_MEM + 32'(k * 64), 512'(k), '1, resp, ok);
         checks++; if (!ok || resp !== 2'b00) begin errors++; $display("FAIL load_word[%0d]: resp %b expected 00", k, resp); end
      end
      axi_write(A_STOP, 512'h0C00, '1, resp, ok);
      axi_write(A_EN, 512'h1, '1, resp, ok);
      for (int i = 0; i < 3 && !axis_0.tvalid; i++) @(negedge aclk);
      idx = 0;
      for (int c = 0; c < 210; c++) begin
         checks++;
         if (axis_0.tvalid !== 1'b1 || axis_0.tdata !== word_val(idx)) begin
            errors++; $display("FAIL long_seq[%0d]: tvalid %b low32 %h expected %h", c, axis_0.tvalid, axis_0.tdata[31:0], word_val(idx) & 512'hFFFF_FFFF);
         end
         idx = (idx + 1) % 48;
         @(negedge aclk);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; bit ok; bit held; logic [511:0] held_data; int idx, xfers;
      axi_write(A_EN, 512'h0, '1, resp, ok);
      axis_0.tready = 1'b0;
      axi_write(A_EN, 512'h1, '1, resp, ok);
      held = 1'b0; held_data = '0; idx = 0; xfers = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge aclk);
         if (held) begin
            checks++;
            if (axis_0.tvalid !== 1'b1 || axis_0.tdata !== held_data) begin
               errors++; $display("FAIL bp_stable[%0d]: tvalid %b data %h expected %h", c, axis_0.tvalid, axis_0.tdata, held_data);
            end
         end
         axis_0.tready = 1'($urandom_range(0, 1));
         held = 1'b0;
         if (axis_0.tvalid) begin
            if (axis_0.tready) begin
               checks++;
               if (axis_0.tdata !== word_val(idx)) begin
                  errors++; $display("FAIL bp_seq[%0d]: got %h expected %h", xfers, axis_0.tdata, word_val(idx));
               end
               idx = (idx + 1) % 48; xfers++;
            end else begin
               held = 1'b1; held_data = axis_0.tdata;
            end
         end
      end
      checks++; if (xfers < 80) begin errors++; $display("FAIL bp_progress: got %0d transfers required at least 80", xfers); end
   endtask

   task automatic test_disable();
      logic [1:0] resp; bit ok;
      axis_0.tready = 1'b0;
      repeat (5) @(negedge aclk);
      axi_write(A_EN, 512'h0, '1, resp, ok);
      @(negedge aclk);
      checks++; if (axis_0.tvalid !== 1'b0) begin errors++; $display("FAIL disable_tvalid: got %b expected 0", axis_0.tvalid); end
      axis_0.tready = 1'b1;
      axi_write(A_EN, 512'h1, '1, resp, ok);
      for (int i = 0; i < 3 && !axis_0.tvalid; i++) @(negedge aclk);
      checks++;
      if (axis_0.tvalid !== 1'b1 || axis_0.tdata !== w0) begin
         errors++; $display("FAIL reenable_first: tvalid %b data %h expected %h", axis_0.tvalid, axis_0.tdata, w0);
      end
   endtask

   task automatic test_degenerate();
      logic [1:0] resp; bit ok;
      axi_write(A_EN, 512'h0, '1, resp, ok);
      axi_write(A_START, 512'h140, '1, resp, ok);
      axi_write(A_STOP, 512'h40, '1, resp, ok);
      axi_write(A_EN, 512'h1, '1, resp, ok);
      for (int i = 0; i < 3 && !axis_0.tvalid; i++) @(negedge aclk);
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (axis_0.tvalid !== 1'b1 || axis_0.tdata !== 512'd5) begin
            errors++; $display("FAIL degenerate[%0d]: tvalid %b low32 %h expected 00000005", c, axis_0.tvalid, axis_0.tdata[31:0]);
         end
         @(negedge aclk);
      end
   endtask

   task automatic test_unmapped();
      logic [1:0] resp; bit ok; logic [511:0] rd;
      axi_write(A_EN, 512'h0, '1, resp, ok);
      axi_write(32'h5000_0000, '1, '1, resp, ok);
      checks++; if (!ok || resp !== 2'b10) begin errors++; $display("FAIL unmapped_bresp: ok %0d resp %b expected 10", ok, resp); end
      axi_read(A_EN, rd, resp, ok);
      checks++; if (!ok || rd !== 512'h0) begin errors++; $display("FAIL unmapped_no_effect: dac_en %h expected 0", rd[31:0]); end
      axi_read(A_STOP, rd, resp, ok);
      checks++; if (!ok || rd !== 512'h40) begin errors++; $display("FAIL stop_readback: got %h expected 00000040", rd[31:0]); end
      axi_read(32'h5000_0000, rd, resp, ok);
      checks++; if (!ok || resp !== 2'b10 || rd !== 512'h0) begin errors++; $display("FAIL unmapped_read: resp %b expected 10, low32 %h expected 0", resp, rd[31:0]); end
   endtask

   task automatic test_async_reset();
      logic [1:0] resp; bit ok; logic [511:0] rd;
      axi_write(A_START, 512'h40, '1, resp, ok);
      axi_write(A_STOP, 512'h100, '1, resp, ok);
      axis_0.tready = 1'b1;
      axi_write(A_EN, 512'h1, '1, resp, ok);
      for (int i = 0; i < 6; i++) @(negedge aclk);
      checks++; if (axis_0.tvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_stream: tvalid %b expected 1", axis_0.tvalid); end
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if (axis_0.tvalid !== 1'b0 || axis_0.tdata !== 512'h0) begin
         errors++; $display("FAIL async_reset_axis: tvalid %b expected 0, low32 %h expected 0", axis_0.tvalid, axis_0.tdata[31:0]);
      end
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      repeat (6) @(negedge aclk);
      checks++; if (axis_0.tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: tvalid %b expected 0", axis_0.tvalid); end
      axi_read(A_EN, rd, resp, ok);
      checks++; if (!ok || rd !== 512'h0) begin errors++; $display("FAIL reset_en_reg: got %h expected 0", rd[31:0]); end
      axi_read(A_START, rd, resp, ok);
      checks++; if (!ok || rd !== 512'h0) begin errors++; $display("FAIL reset_start_reg: got %h expected 0", rd[31:0]); end
      axi_read(A_STOP, rd, resp, ok);
      checks++; if (!ok || rd !== 512'h0) begin errors++; $display("FAIL reset_stop_reg: got %h expected 0", rd[31:0]); end
   endtask

   initial begin
      s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 1'b0; s_axi.bready = 1'b1; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b1; axis_0.tready = 1'b0;
      w0 = '0; w1 = '0;
      for (int g = 0; g < 16; g++) begin
         w0[128 + (15 - g) * 16 +: 16] = 16'(g + 1);
         w1[128 + (15 - g) * 16 +: 16] = (g < 15) ? 16'((g + 1) * 16'h1111) : 16'h0;
      end
      test_reset();
      test_mem_rw();
      test_alternate();
      test_long_seq();
      test_backpressure();
      test_disable();
      test_degenerate();
      test_unmapped();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
